rect_scan: RTL

RECT_SCAN -- requirements
Module: rect_scan

---
 rtl/rect_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rect_scan.sv
// Purpose : raster scan of an inclusive pixel window in a frame, emitting x/y and linear address.
// Latency : first pixel 1 cycle after an accepted start, then 1 pixel/cycle; done 1 cycle after last pixel.
// Backpr. : stall=1 holds the current pixel and suppresses done/frame_end; abort ends the scan next edge.
//
// Ports:
//   clk50M, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort, cont     scan request, scan termination, continuous-mode select (latched at start)
//   stall                  downstream not ready: hold the presented pixel
//   x0/x1, y0/y1           inclusive window bounds (latched at start)
//   x, y, addr, valid      current pixel column/row, y*H_RES+x, pixel-present qualifier
//   busy, done, frame_end  SCAN state, single-pass end pulse, continuous-mode wrap pulse
//   err                    pulse when start is rejected because the window is illegal
module rect_scan #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int AW    = 15
) (
  input  logic          clk50M,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          cont,
  input  logic          stall,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic          frame_end,
  output logic          err
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  localparam logic [AW-1:0] LP_HRES = AW'(H_RES);

  state_t        r_state;
  logic [XW-1:0] r_x, r_x0, r_x1;
  logic [YW-1:0] r_y, r_y0, r_y1;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_addr0;     // address of (x0,y0), reloaded on each continuous-mode wrap
  logic [AW-1:0] r_row_step;  // H_RES-(x1-x0): jump from (x1,y) to (x0,y+1)
  logic          r_cont;
  logic          r_done, r_frame_end, r_err;

  logic          w_legal;
  logic [AW-1:0] w_start_addr;
  logic [AW-1:0] w_row_step;

  assign w_legal = (x0 <= x1) && (y0 <= y1) && (int'(x1) < H_RES) && (int'(y1) < V_RES);

  // The only multiply is at window setup, never in the per-pixel advance.
  assign w_start_addr = AW'(y0) * LP_HRES + AW'(x0);
  assign w_row_step   = LP_HRES - AW'(x1 - x0);

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_addr0     <= '0;
      r_row_step  <= '0;
      r_cont      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_end <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      r_done      <= 1'b0;
      r_frame_end <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // abort in IDLE swallows a coincident start.
          if (start && !abort) begin
            if (w_legal) begin
              r_x0       <= x0;
              r_x1       <= x1;
              r_y0       <= y0;
              r_y1       <= y1;
              r_cont     <= cont;
              r_x        <= x0;
              r_y        <= y0;
              r_addr     <= w_start_addr;
              r_addr0    <= w_start_addr;
              r_row_step <= w_row_step;
              r_state    <= ST_SCAN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (!stall) begin
            if (r_x == r_x1) begin
              if (r_y == r_y1) begin
                if (r_cont) begin
                  r_x         <= r_x0;
                  r_y         <= r_y0;
                  r_addr      <= r_addr0;
                  r_frame_end <= 1'b1;
                end else begin
                  // Position holds its last value into IDLE.
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_x    <= r_x0;
                r_y    <= r_y + YW'(1);
                r_addr <= r_addr + r_row_step;
              end
            end else begin
              r_x    <= r_x + XW'(1);
              r_addr <= r_addr + AW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign addr      = r_addr;
  assign busy      = (r_state == ST_SCAN);
  assign valid     = (r_state == ST_SCAN);
  assign done      = r_done;
  assign frame_end = r_frame_end;
  assign err       = r_err;

endmodule
